// File: rtl/freelist_bank_if.sv
// Rename/retire-side bundle for the free-list bank: allocation requests from rename,
// pointer-block state, retire writebacks, and the bank's registered allocation results.
interface freelist_bank_if #(
    parameter int PR_W = 7
);
    logic            flush_stage4;
    logic            stage4_pause;
    logic [1:0]      alloc_req;
    logic [PR_W-1:0] rd_ptr;
    logic [PR_W-1:0] freelist_room;
    logic [1:0]      free_valid;
    logic [PR_W-1:0] free_pr0;
    logic [PR_W-1:0] free_pr1;
    logic [1:0]      PR_num_need;
    logic [1:0]      PR_num_wrback;
    logic            alloc_stall;
    logic [1:0]      alloc_valid;
    logic [PR_W-1:0] alloc_pr0;
    logic [PR_W-1:0] alloc_pr1;
    logic            overflow_err;

    modport slave (
        input  flush_stage4, stage4_pause, alloc_req, rd_ptr, freelist_room,
               free_valid, free_pr0, free_pr1,
        output PR_num_need, PR_num_wrback, alloc_stall, alloc_valid,
               alloc_pr0, alloc_pr1, overflow_err
    );

    modport master (
        output flush_stage4, stage4_pause, alloc_req, rd_ptr, freelist_room,
               free_valid, free_pr0, free_pr1,
        input  PR_num_need, PR_num_wrback, alloc_stall, alloc_valid,
               alloc_pr0, alloc_pr1, overflow_err
    );
endinterface

// File: rtl/freelist_bank.sv
// Circular buffer of free physical-register IDs for the 2-wide rename stage:
// pops up to two PRs per cycle for rename, accepts up to two freed PRs per cycle from retire.
module freelist_bank #(
    parameter int PR_W   = 7,
    parameter int DEPTH  = 64,
    parameter int AR_NUM = 32
) (
    input logic           clk,
    input logic           rst,
    freelist_bank_if.slave bus
);
    localparam int AW = PR_W - 1;

    logic [PR_W-1:0] mem_q [DEPTH];
    logic [PR_W-1:0] wr_idx_q;
    logic [1:0]      alloc_valid_q;
    logic [PR_W-1:0] alloc_pr0_q, alloc_pr1_q;
    logic            overflow_q;

    logic [1:0]      need, nwb;
    logic            stall;
    logic [AW-1:0]   rd_a0, rd_a1, wr_a0, wr_a1;
    logic [PR_W-1:0] lk0, lk1, wdat0;
    logic [PR_W:0]   room_after;
    logic            ovf_now;

    always_comb begin
        need  = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
        nwb   = {1'b0, bus.free_valid[0]} + {1'b0, bus.free_valid[1]};
        stall = (PR_W'(need) > bus.freelist_room) && !bus.flush_stage4;
        // Lanes are compacted: lane1 reads past lane0 only when lane0 also requests.
        rd_a0 = bus.rd_ptr[AW-1:0];
        rd_a1 = rd_a0 + AW'(bus.alloc_req[0]);
        lk0   = mem_q[rd_a0];
        lk1   = mem_q[rd_a1];
        wr_a0 = wr_idx_q[AW-1:0];
        wr_a1 = wr_a0 + AW'(1);
        wdat0 = bus.free_valid[0] ? bus.free_pr0 : bus.free_pr1;
        room_after = {1'b0, bus.freelist_room} + (PR_W+1)'(nwb);
        ovf_now    = room_after > (PR_W+1)'(DEPTH);
    end

    assign bus.PR_num_need   = (bus.flush_stage4 || bus.stage4_pause || stall) ? 2'd0 : need;
    assign bus.PR_num_wrback = nwb;
    assign bus.alloc_stall   = stall;
    assign bus.alloc_valid   = alloc_valid_q;
    assign bus.alloc_pr0     = alloc_pr0_q;
    assign bus.alloc_pr1     = alloc_pr1_q;
    assign bus.overflow_err  = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_valid_q <= 2'b00;
            alloc_pr0_q   <= '0;
            alloc_pr1_q   <= '0;
        end else if (bus.flush_stage4) begin
            alloc_valid_q <= 2'b00;
        end else if (!bus.stage4_pause) begin
            if (stall) begin
                alloc_valid_q <= 2'b00;
            end else begin
                alloc_valid_q <= bus.alloc_req;
                alloc_pr0_q   <= lk0;
                alloc_pr1_q   <= lk1;
            end
        end
    end

    // Retire writeback is independent of flush/pause; overflow is flagged but the write still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= PR_W'(AR_NUM + i);
            wr_idx_q   <= PR_W'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            if (|bus.free_valid) mem_q[wr_a0] <= wdat0;
            if (&bus.free_valid) mem_q[wr_a1] <= bus.free_pr1;
            wr_idx_q <= wr_idx_q + PR_W'(nwb);
            if (ovf_now) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_freelist_bank.sv
// Self-checking bench for freelist_bank: directed scenarios plus a randomized run where the
// bench plays the pointer block, checked against a queue/array reference model.
module tb_freelist_bank;
    localparam int PR_W   = 7;
    localparam int DEPTH  = 64;
    localparam int AR_NUM = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    freelist_bank_if #(.PR_W(PR_W)) bif();

    freelist_bank #(.PR_W(PR_W), .DEPTH(DEPTH), .AR_NUM(AR_NUM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: free-list contents, write position, sticky overflow, output registers.
    int       ref_mem [DEPTH];
    int       ref_wr;
    bit       ref_ovf;
    bit [1:0] ref_vld;
    int       ref_pr0, ref_pr1;
    int       last_need, last_n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = AR_NUM + i;
        ref_wr  = DEPTH;
        ref_ovf = 1'b0;
        ref_vld = 2'b00;
        ref_pr0 = 0;
        ref_pr1 = 0;
    endtask

    task automatic drive(input bit fl, input bit pa, input bit [1:0] req, input int rd,
                         input int room, input bit [1:0] fv, input int f0, input int f1);
        bif.flush_stage4  = fl;
        bif.stage4_pause  = pa;
        bif.alloc_req     = req;
        bif.rd_ptr        = PR_W'(rd);
        bif.freelist_room = PR_W'(room);
        bif.free_valid    = fv;
        bif.free_pr0      = PR_W'(f0);
        bif.free_pr1      = PR_W'(f1);
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs after the edge.
    task automatic step(input string tag);
        int fl, pa, rd, room, need, n, en;
        bit stall;
        bit [1:0] req, fv;
        int wq[$];
        fl = bif.flush_stage4; pa = bif.stage4_pause;
        req = bif.alloc_req; fv = bif.free_valid;
        rd = bif.rd_ptr; room = bif.freelist_room;
        need = req[0] + req[1];
        n = fv[0] + fv[1];
        stall = (need > room) && (fl == 0);
        en = (fl != 0 || pa != 0 || stall) ? 0 : need;
        #1;
        chk({tag, "/need"},   32'(bif.PR_num_need),   32'(en));
        chk({tag, "/stall"},  32'(bif.alloc_stall),   32'(stall));
        chk({tag, "/wrback"}, 32'(bif.PR_num_wrback), 32'(n));
        if (fl != 0) ref_vld = 2'b00;
        else if (pa == 0) begin
            if (stall) ref_vld = 2'b00;
            else begin
                ref_vld = req;
                ref_pr0 = ref_mem[rd % DEPTH];
                ref_pr1 = ref_mem[(rd + req[0]) % DEPTH];
            end
        end
        if (fv[0]) wq.push_back(int'(bif.free_pr0));
        if (fv[1]) wq.push_back(int'(bif.free_pr1));
        foreach (wq[k]) begin
            ref_mem[ref_wr % DEPTH] = wq[k];
            ref_wr = (ref_wr + 1) % (2 * DEPTH);
        end
        if (room + n > DEPTH) ref_ovf = 1'b1;
        last_need = en;
        last_n = n;
        @(posedge clk);
        #1;
        chk({tag, "/vld"}, 32'(bif.alloc_valid), 32'(ref_vld));
        if (ref_vld[0]) chk({tag, "/pr0"}, 32'(bif.alloc_pr0), 32'(ref_pr0));
        if (ref_vld[1]) chk({tag, "/pr1"}, 32'(bif.alloc_pr1), 32'(ref_pr1));
        chk({tag, "/ovf"}, 32'(bif.overflow_err), 32'(ref_ovf));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "/rst_vld"}, 32'(bif.alloc_valid),  32'(0));
        chk({tag, "/rst_pr0"}, 32'(bif.alloc_pr0),    32'(0));
        chk({tag, "/rst_pr1"}, 32'(bif.alloc_pr1),    32'(0));
        chk({tag, "/rst_ovf"}, 32'(bif.overflow_err), 32'(0));
        drive(0, 0, 2'b00, 0, DEPTH, 2'b00, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p_rd, p_wr, room, n;
        bit [1:0] req, fv;
        drive(0, 0, 2'b00, 0, DEPTH, 2'b00, 0, 0);
        #2;
        do_reset("r0");

        // Both lanes from a fresh list, then lane1 alone compacted onto rd_ptr.
        drive(0, 0, 2'b11, 0, 64, 2'b00, 0, 0);  step("both");
        drive(0, 0, 2'b10, 5, 64, 2'b00, 0, 0);  step("lane1");
        // Room boundary: 1 entry stalls a 2-wide request, 2 entries grant it.
        drive(0, 0, 2'b11, 0, 1, 2'b00, 0, 0);   step("room1");
        drive(0, 0, 2'b11, 0, 2, 2'b00, 0, 0);   step("room2");
        // Pause holds, flush beats pause.
        drive(0, 0, 2'b11, 2, 60, 2'b00, 0, 0);  step("pre_pause");
        drive(0, 1, 2'b11, 4, 58, 2'b00, 0, 0);  step("pause");
        drive(0, 1, 2'b01, 4, 58, 2'b00, 0, 0);  step("pause2");
        drive(1, 1, 2'b11, 4, 58, 2'b00, 0, 0);  step("flush_pause");
        drive(1, 0, 2'b11, 4, 0, 2'b00, 0, 0);   step("flush_noroom");

        // Lane1-only writeback lands at entry 0; reading pointer 64 wraps to it.
        do_reset("r1");
        drive(0, 0, 2'b00, 0, 63, 2'b10, 0, 9);  step("wb_lane1");
        drive(0, 0, 2'b01, 64, 64, 2'b00, 0, 0); step("wrap");

        // Randomized run: bench acts as the pointer block.
        do_reset("r2");
        p_rd = 0;
        p_wr = DEPTH;
        for (int c = 0; c < 600; c++) begin
            room = (p_wr - p_rd) & (2 * DEPTH - 1);
            req = 2'($urandom_range(0, 3));
            fv  = 2'($urandom_range(0, 3));
            n   = fv[0] + fv[1];
            if (room + n > DEPTH) fv = 2'b00;
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), req, p_rd, room, fv,
                  $urandom_range(0, 127), $urandom_range(0, 127));
            step("rand");
            p_rd = (p_rd + last_need) % (2 * DEPTH);
            p_wr = (p_wr + last_n) % (2 * DEPTH);
        end

        // Overflow is sticky across later idle and allocating cycles.
        drive(0, 0, 2'b00, p_rd, 64, 2'b01, 7, 0);  step("ovf_set");
        drive(0, 0, 2'b11, p_rd, 10, 2'b00, 0, 0);  step("ovf_hold1");
        drive(0, 0, 2'b00, p_rd, 10, 2'b00, 0, 0);  step("ovf_hold2");
        // Asynchronous reset mid-activity clears everything at once.
        drive(0, 0, 2'b11, p_rd, 10, 2'b11, 1, 2);  step("pre_rst");
        do_reset("r3");
        drive(0, 0, 2'b11, 0, 64, 2'b00, 0, 0);  step("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
